// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: round-robin owner of the single VRAM write port.
// Bounded bursts keep one requester from starving the others.
module vram_write_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int ADDR_BITS  = 13,
  parameter int DATA_BITS  = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [REQUESTERS-1:0]           req_valid,
  output logic [REQUESTERS-1:0]           req_ready,
  input  logic [REQUESTERS-1:0]           req_last,
  input  logic [REQUESTERS*ADDR_BITS-1:0] req_addr,
  input  logic [REQUESTERS*DATA_BITS-1:0] req_data,
  input  logic                            vram_stall,
  output logic                            vram_we,
  output logic [ADDR_BITS-1:0]            vram_addr,
  output logic [DATA_BITS-1:0]            vram_data,
  output logic                            grant_valid,
  output logic [$clog2(REQUESTERS)-1:0]   grant_id
);

  localparam int IDW = $clog2(REQUESTERS);
  localparam int CW  = $clog2(MAX_BURST + 1);

  localparam logic [IDW-1:0] LAST_ID   = IDW'(REQUESTERS - 1);
  localparam logic [CW-1:0]  BURST_END = CW'(MAX_BURST);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] data_q, data_d;

  logic                 pick_found;
  logic [IDW-1:0]       pick_idx;
  logic                 own_valid;
  logic                 own_last;
  logic [ADDR_BITS-1:0] own_addr;
  logic [DATA_BITS-1:0] own_data;
  logic                 in_grant;
  logic                 beat;
  logic [CW-1:0]        beat_inc;
  logic                 rel;
  logic [IDW-1:0]       next_ptr;

  assign own_valid = req_valid[owner_q];
  assign own_last  = req_last[owner_q];
  assign own_addr  = req_addr[owner_q*ADDR_BITS +: ADDR_BITS];
  assign own_data  = req_data[owner_q*DATA_BITS +: DATA_BITS];

  assign in_grant = (state_q == GRANT);
  assign beat     = in_grant & own_valid & ~vram_stall;
  assign beat_inc = beat_cnt_q + 1'b1;
  assign next_ptr = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;

  // Ownership ends on a last beat, a full burst, or the owner going idle.
  assign rel = in_grant &
               (~own_valid |
                (beat & (own_last | (beat_inc == BURST_END))));

  // Scan for the first valid requester starting at the round-robin pointer.
  always_comb begin
    logic [IDW:0] sum;
    pick_found = 1'b0;
    pick_idx   = '0;
    sum        = '0;
    for (int k = 0; k < REQUESTERS; k++) begin
      sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(REQUESTERS)) begin
        sum = sum - (IDW+1)'(REQUESTERS);
      end
      if (!pick_found && req_valid[sum[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = sum[IDW-1:0];
      end
    end
  end

  // Only the owner may be ready, and only while the VRAM port is free.
  always_comb begin
    req_ready = '0;
    if (in_grant && !vram_stall) begin
      req_ready[owner_q] = 1'b1;
    end
  end

  // Next-state logic for the arbiter FSM and the registered write port.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found && !vram_stall) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (beat) begin
          we_d       = 1'b1;
          addr_d     = own_addr;
          data_d     = own_data;
          beat_cnt_d = beat_inc;
        end
        if (rel) begin
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end
      end
    endcase
  end

  // State and output registers; reset aborts any burst in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign vram_we     = we_q;
  assign vram_addr   = addr_q;
  assign vram_data   = data_q;
  assign grant_valid = in_grant;
  assign grant_id    = owner_q;

endmodule

// File: doc/vram_write_arbiter.md
Name: vram_write_arbiter

Overview:
- Shares the single VRAM write port of mini16_soc among REQUESTERS producers, e.g. PE clusters and the UART debug path.
- Uses round-robin arbitration with bounded bursts, so one PE cluster cannot starve the others while drawing a frame.
- Sits in the clk domain, between the requesters and the VRAM write side. The VGA scan-out side in clkv is untouched.

Parameters:
- REQUESTERS, 4, number of requesters (2..16).
- ADDR_BITS, 13, VRAM word address width (VRAM_WIDTH_BITS + VRAM_HEIGHT_BITS).
- DATA_BITS, 16, VRAM write data width.
- MAX_BURST, 8, maximum beats per grant (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  REQUESTERS  per-requester write valid.
- req_ready  out  REQUESTERS  per-requester accept.
- req_last  in  REQUESTERS  marks the final beat of the requester's burst.
- req_addr  in  REQUESTERS*ADDR_BITS  flat vector; requester i occupies [i*ADDR_BITS +: ADDR_BITS].
- req_data  in  REQUESTERS*DATA_BITS  flat vector; requester i occupies [i*DATA_BITS +: DATA_BITS].
- vram_stall  in  1  VRAM port cannot accept writes this cycle.
- vram_we  out  1  registered write enable.
- vram_addr  out  ADDR_BITS  registered write address.
- vram_data  out  DATA_BITS  registered write data.
- grant_valid  out  1  a requester currently owns the port (state GRANT).
- grant_id  out  clog2(REQUESTERS)  current or last owner index.

Behaviour:
- Reset, asynchronous: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0.
- Reset values of outputs: vram_we=0, vram_addr=0, vram_data=0, req_ready=0, grant_valid=0, grant_id=0.
- Reset asserted mid-burst aborts immediately. The partial burst is not resumed.
- State IDLE:
  - req_ready=0 for all requesters.
  - If any req_valid=1 and vram_stall=0: choose the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap at REQUESTERS.
  - Then set owner=i, grant_id=i, beat_cnt=0, go to GRANT.
  - The arbitration cycle transfers nothing.
  - If vram_stall=1, stay in IDLE.
- State GRANT:
  - req_ready[owner] = ~vram_stall. All other ready bits are 0.
  - req_ready is combinational from registered state and vram_stall only. It never depends on req_valid.
  - Beat = req_valid[owner] & req_ready[owner].
  - On a beat, next cycle: vram_we=1, vram_addr/vram_data = owner's addr/data from the beat cycle. Latency is exactly 1 cycle.
  - On a beat, beat_cnt increments.
  - vram_we=0 on every cycle following a non-beat cycle. vram_addr/vram_data hold their last values.
- Release conditions, evaluated each GRANT cycle:
  - (a) a beat with req_last[owner]=1;
  - (b) a beat with beat_cnt+1 == MAX_BURST;
  - (c) req_valid[owner]=0, including during a stall. No beat occurs in this case.
- On release: rr_ptr = (owner+1) mod REQUESTERS, go to IDLE.
- Sustained throughput: up to MAX_BURST beats per MAX_BURST+1 cycles.
- A requester cut off by MAX_BURST keeps its remaining beats pending. It is re-arbitrated after every other valid requester has had one grant.
- Stall during GRANT: no beat and no count change. The owner is retained unless (c) applies.
- grant_valid = (state==GRANT).
- Requester protocol: once req_valid is raised, addr/data/last must stay stable until the beat. The arbiter does not check this.
- Fairness: with all requesters continuously valid, grant order is 0,1,2,...,REQUESTERS-1,0,...
- Fairness bound: no requester waits more than (REQUESTERS-1)*(MAX_BURST+1)+1 cycles, excluding stall cycles.
- Width rules:
  - rr_ptr and owner use clog2(REQUESTERS) bits, wrapping explicitly, so non-power-of-2 REQUESTERS is legal.
  - beat_cnt uses clog2(MAX_BURST+1) bits.

Test Plan:
- Single requester: req 2 valid with 3 beats (addr 0x0010..0x0012, data 0xA000..0xA002, last on the 3rd) → req_ready[2] high from cycle 1; vram_we pulses on cycles 2,3,4 with matching addr/data; then IDLE; rr_ptr=3.
- All four continuously valid, last never asserted, MAX_BURST=8 → grant_id sequence 0,1,2,3,0; each grant has exactly 8 vram_we pulses followed by 1 idle cycle.
- Contention with priority: rr_ptr=3, req 1 and req 3 valid simultaneously → req 3 is granted first, then req 1.
- vram_stall=1 for 5 cycles in the middle of req 0's burst → req_ready[0]=0 and no vram_we during the stall; beat count is preserved; the burst completes after the stall with no lost or duplicated beats (address sequence is continuous).
- Owner drops req_valid after 2 of 8 beats → release next cycle; the next valid requester is granted; vram_we count for owner=2.
- Assert reset during the 4th beat of a burst → all outputs go to 0 immediately (asynchronously); after deassertion, the first grant goes to the lowest-indexed valid requester (rr_ptr=0).
